fir_mac_seq: RTL and testbench

Time-multiplexed, parametrised successor to the combinational 8-tap MAC. It holds an internal sample delay line and a writable coefficient bank, and accepts one sample per valid/ready handshake. It accumulates NUM_TAPS products over NUM_TAPS cycles using a single multiplier, then returns a rounded Q-format result on a valid/ready output. It sits between the sample source and the FIR output stage of the accelerator.

---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_round_sat.sv | 43 ++++
 rtl/fir_mac_seq.sv | 113 +++++++++++
 tb/tb_fir_mac_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the sequential FIR MAC and its helper stages.
package fir_pkg;

    localparam int FIR_DATA_WIDTH = 32;
    localparam int FIR_FRAC_BITS  = 16;
    localparam int FIR_NUM_TAPS   = 8;
    localparam int FIR_ACC_WIDTH  = 2*FIR_DATA_WIDTH + $clog2(FIR_NUM_TAPS);

    typedef logic signed [FIR_DATA_WIDTH-1:0] sample_t;
    typedef logic signed [FIR_ACC_WIDTH-1:0]  acc_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUTPUT
    } mac_state_e;

endpackage

// File: rtl/fir_round_sat.sv
// Q-format round-half-up of a wide accumulator down to a sample; clamps when FIR_MAC_SAT_EN is defined, otherwise wraps.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module fir_round_sat #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int ACC_WIDTH  = 67
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
`ifdef FIR_MAC_SAT_EN
    output logic                         sat,
`endif
    output logic signed [DATA_WIDTH-1:0] res
);

    localparam logic signed [ACC_WIDTH-1:0] HALF =
        {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (FRAC_BITS-1);

`ifdef FIR_MAC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] MAXV =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MINV =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] rnd;
    assign rnd = (acc + HALF) >>> FRAC_BITS;

    always_comb begin
        sat = 1'b0;
        res = rnd[DATA_WIDTH-1:0];
        if (rnd > MAXV) begin
            sat = 1'b1;
            res = MAXV[DATA_WIDTH-1:0];
        end else if (rnd < MINV) begin
            sat = 1'b1;
            res = MINV[DATA_WIDTH-1:0];
        end
    end
`else
    assign res = DATA_WIDTH'((acc + HALF) >>> FRAC_BITS);
`endif

endmodule

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR MAC: one multiplier walks NUM_TAPS taps per sample; FIR_MAC_SAT_EN adds clamping and sat_flag.
// Latency: NUM_TAPS accumulate cycles after the accept edge, result registered on entry to OUTPUT; one sample per NUM_TAPS+2 cycles.
// Backpressure: in_ready low while busy; result held stable in OUTPUT until out_ready.
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter  int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter  int NUM_TAPS   = FIR_NUM_TAPS,
    parameter  int FRAC_BITS  = FIR_FRAC_BITS,
    localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(NUM_TAPS),
    localparam int IDXW       = $clog2(NUM_TAPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    input  logic                         coef_we,
    input  logic [IDXW-1:0]              coef_addr,
    input  logic signed [DATA_WIDTH-1:0] coef_data,
`ifdef FIR_MAC_SAT_EN
    output logic                         sat_flag,
`endif
    output logic                         busy
);

    mac_state_e                  state;
    logic signed [DATA_WIDTH-1:0] taps  [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] coefs [NUM_TAPS];
    logic signed [ACC_WIDTH-1:0]  acc;
    logic [IDXW-1:0]              idx;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_next;
    logic signed [DATA_WIDTH-1:0]   rnd;

    assign prod     = (2*DATA_WIDTH)'(coefs[idx]) * (2*DATA_WIDTH)'(taps[idx]);
    assign acc_next = acc + ACC_WIDTH'(prod);

    // Rounds the running sum including the current term, so the last ACCUM edge can register the result directly.
`ifdef FIR_MAC_SAT_EN
    logic rnd_sat;
    fir_round_sat #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS), .ACC_WIDTH(ACC_WIDTH))
        u_round (.acc(acc_next), .sat(rnd_sat), .res(rnd));
`else
    fir_round_sat #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS), .ACC_WIDTH(ACC_WIDTH))
        u_round (.acc(acc_next), .res(rnd));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            for (int k = 0; k < NUM_TAPS; k++) begin
                taps[k]  <= '0;
                coefs[k] <= '0;
            end
            acc       <= '0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
`ifdef FIR_MAC_SAT_EN
            sat_flag  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (coef_we && (int'(coef_addr) < NUM_TAPS))
                        coefs[coef_addr] <= coef_data;
                    if (in_valid) begin
                        taps[0] <= in_data;
                        for (int k = 1; k < NUM_TAPS; k++)
                            taps[k] <= taps[k-1];
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (idx == IDXW'(NUM_TAPS-1)) begin
                        out_data  <= rnd;
                        out_valid <= 1'b1;
`ifdef FIR_MAC_SAT_EN
                        sat_flag  <= rnd_sat;
`endif
                        state     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
`ifdef FIR_MAC_SAT_EN
                        sat_flag  <= 1'b0;
`endif
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq: Q16.16 vectors with hand-computed results.
module tb_fir_mac_seq;
    import fir_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    sample_t     in_data;
    logic        out_valid;
    logic        out_ready;
    sample_t     out_data;
    logic        coef_we;
    logic [2:0]  coef_addr;
    sample_t     coef_data;
    logic        busy;
`ifdef FIR_MAC_SAT_EN
    logic        sat_flag;
    logic        last_sat;
`endif

    int total = 0;
    int bad   = 0;

    fir_mac_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
`ifdef FIR_MAC_SAT_EN
        .sat_flag(sat_flag),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wcoef(input int a, input logic [31:0] d);
        coef_we   = 1'b1;
        coef_addr = 3'(a);
        coef_data = d;
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv(output logic [31:0] r);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("recv_timeout", {31'd0, out_valid}, 32'd1);
        r = out_data;
`ifdef FIR_MAC_SAT_EN
        last_sat = sat_flag;
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run(input logic [31:0] d, output logic [31:0] r);
        send(d);
        recv(r);
    endtask

    logic [31:0] r;
    logic [31:0] hold;
    logic [31:0] clist [8];
    logic [31:0] hist  [8];
    int          n;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data,           32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);

        // Unit coefficients, unit samples: output n is n.0 while history fills.
        for (int k = 0; k < 8; k++) wcoef(k, 32'h0001_0000);
        for (int i = 1; i <= 8; i++) begin
            run(32'h0001_0000, r);
            chk($sformatf("ones_%0d", i), r, 32'(i) << 16);
        end

        // Back-to-back throughput with both sides always ready.
        in_valid = 1'b1; in_data = 32'h0001_0000; out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("period", 32'(n), 32'd10);

        // 0.2 coefficients over history summing to 17: 13107*17.
        for (int k = 0; k < 8; k++) wcoef(k, 32'd13107);
        hist = '{32'd2, 32'd1, 32'd1, 32'd4, 32'd1, 32'd5, 32'd2, 32'd1};
        for (int i = 0; i < 8; i++) run(hist[i] << 16, r);
        chk("fifth_sum", r, 32'd222819);

        // Reset in the middle of ACCUM discards the sample and clears history.
        send(32'h0001_0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy",      {31'd0, busy},      32'd0);

        clist = '{32'h0000_1000, 32'hFFFF_F000, 32'h0002_0000, 32'h0000_0007,
                  32'hFFFE_0000, 32'h0001_2345, 32'h0000_0001, 32'hFFFF_FFFF};
        for (int k = 0; k < 8; k++) wcoef(k, clist[k]);
        for (int i = 0; i < 8; i++) begin
            run((i == 0) ? 32'h0001_0000 : 32'h0, r);
            chk($sformatf("impulse_%0d", i), r, clist[i]);
        end

        // Output stall: result held, inputs refused.
        send(32'h0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        hold = out_data;
        chk("bp_value", hold, 32'h0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h0005_0000;
            @(negedge clk);
            chk($sformatf("bp_data_%0d", i),  out_data,             hold);
            chk($sformatf("bp_valid_%0d", i), {31'd0, out_valid},   32'd1);
            chk($sformatf("bp_ready_%0d", i), {31'd0, in_ready},    32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("rel_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rel_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rel_busy",      {31'd0, busy},      32'd0);
        run(32'h0, r);
        chk("bp_not_consumed", r, 32'h0);

        // Coefficient write during ACCUM is dropped.
        send(32'h0001_0000);
        chk("accum_busy", {31'd0, busy}, 32'd1);
        wcoef(0, 32'h0000_7777);
        recv(r);
        chk("we_accum_cur", r, 32'h0000_1000);
        run(32'h0002_0000, r);
        chk("we_accum_next", r, 32'h0000_1000);

        // Write and accept on the same IDLE edge: new coefficient applies.
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 32'h0000_7777;
        in_valid = 1'b1; in_data = 32'h0001_0000;
        @(negedge clk);
        coef_we = 1'b0; in_valid = 1'b0;
        recv(r);
        chk("we_idle_same_edge", r, 32'h0002_5777);

        // Overflow handling: 16384.0 samples under unit coefficients.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) wcoef(k, 32'h0001_0000);
        for (int i = 1; i <= 8; i++) begin
            run(32'h4000_0000, r);
            if (i == 1) chk("big_1", r, 32'h4000_0000);
`ifdef FIR_MAC_SAT_EN
            if (i == 1) chk("big_1_flag", {31'd0, last_sat}, 32'd0);
            if (i == 2) chk("big_2", r, 32'h7FFF_FFFF);
            if (i == 8) chk("big_8", r, 32'h7FFF_FFFF);
            if (i == 8) chk("big_8_flag", {31'd0, last_sat}, 32'd1);
`else
            if (i == 2) chk("big_2", r, 32'h8000_0000);
            if (i == 8) chk("big_8", r, 32'h0000_0000);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
